// File: rtl/axi4_lite_arbiter_2to1_pkg.sv
// Shared constants for the 2:1 AXI4-Lite arbiter: response codes, FSM encodings
// and the round-robin decision.
package axi4_lite_arbiter_2to1_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI4_ARB_IDLE   = 2'd0;
  localparam logic [1:0] AXI4_ARB_IFU_RD = 2'd1;
  localparam logic [1:0] AXI4_ARB_LSU_RD = 2'd2;
  localparam logic [1:0] AXI4_ARB_LSU_WR = 2'd3;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  // On a tie the master that did not win last time is picked.
  function automatic logic rr_grant_lsu(input logic ifu_req, input logic lsu_req,
                                        input logic last_grant);
    return lsu_req && (!ifu_req || (last_grant == GRANT_IFU));
  endfunction

endpackage

// File: rtl/axi4_lite_arbiter_2to1.sv
// Round-robin 2:1 AXI4-Lite arbiter (IFU read port + LSU read/write port), one transaction at a time.
// Grant is registered (request at t -> m_ side at t+1); granted channels pass ready/valid straight through.
module axi4_lite_arbiter_2to1
  import axi4_lite_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,

  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,

  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  logic [1:0] state, state_nxt;
  logic       last_grant;
  logic       grant_vld, grant_lsu;
  logic       ar_done, aw_done, w_done;
  logic       ifu_req, lsu_req, lsu_wr_req;

  assign ifu_req    = ifu_arvalid;
  assign lsu_wr_req = lsu_awvalid || lsu_wvalid;
  assign lsu_req    = lsu_wr_req || lsu_arvalid;

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_lsu = 1'b0;
    case (state)
      AXI4_ARB_IDLE: begin
        if (ifu_req || lsu_req) begin
          grant_vld = 1'b1;
          grant_lsu = rr_grant_lsu(ifu_req, lsu_req, last_grant);
          if (!grant_lsu)      state_nxt = AXI4_ARB_IFU_RD;
          else if (lsu_wr_req) state_nxt = AXI4_ARB_LSU_WR;
          else                 state_nxt = AXI4_ARB_LSU_RD;
        end
      end
      AXI4_ARB_IFU_RD,
      AXI4_ARB_LSU_RD: if (m_rvalid && m_rready) state_nxt = AXI4_ARB_IDLE;
      AXI4_ARB_LSU_WR: if (m_bvalid && m_bready) state_nxt = AXI4_ARB_IDLE;
      default:         state_nxt = AXI4_ARB_IDLE;
    endcase
  end

  // Done flags stop a master that issues its next address early from leaking a
  // second request into the slave while the current response is still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= AXI4_ARB_IDLE;
      last_grant <= GRANT_LSU;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_vld) last_grant <= grant_lsu;
      if (state == AXI4_ARB_IDLE) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (m_arvalid && m_arready) ar_done <= 1'b1;
        if (m_awvalid && m_awready) aw_done <= 1'b1;
        if (m_wvalid && m_wready)   w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    case (state)
      AXI4_ARB_IFU_RD: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid && !ar_done;
        ifu_arready = m_arready && !ar_done;
        m_rready    = ifu_rready;
        ifu_rvalid  = m_rvalid;
      end
      AXI4_ARB_LSU_RD: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid && !ar_done;
        lsu_arready = m_arready && !ar_done;
        m_rready    = lsu_rready;
        lsu_rvalid  = m_rvalid;
      end
      AXI4_ARB_LSU_WR: begin
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid && !aw_done;
        lsu_awready = m_awready && !aw_done;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid && !w_done;
        lsu_wready  = m_wready && !w_done;
        m_bready    = lsu_bready;
        lsu_bvalid  = m_bvalid;
      end
      default: ;
    endcase
  end

  assign ifu_rdata = m_rdata;
  assign ifu_rresp = m_rresp;
  assign lsu_rdata = m_rdata;
  assign lsu_rresp = m_rresp;
  assign lsu_bresp = m_bresp;

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for axi4_lite_arbiter_2to1: cycle tables for single-master traffic,
// hand sequences for ties, ordering, back-pressure and mid-transaction reset.
module tb_axi4_lite_arbiter_2to1;
  import axi4_lite_arbiter_2to1_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ifu_araddr, lsu_awaddr, lsu_wdata, lsu_araddr, m_rdata;
  logic [31:0] ifu_rdata, lsu_rdata, m_awaddr, m_wdata, m_araddr;
  logic [3:0]  lsu_wstrb, m_wstrb;
  logic [1:0]  ifu_rresp, lsu_bresp, lsu_rresp, m_bresp, m_rresp;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  axi4_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // iv = {ifu_arvalid,ifu_rready}_{lsu_awvalid,wvalid,bready,arvalid,rready}_{m_awready,wready,bvalid,arready,rvalid}
  // ov = {m_arvalid,m_rready,ifu_arready,ifu_rvalid}_{m_awvalid,m_wvalid,m_bready,lsu_awready,lsu_wready,lsu_bvalid}_{lsu_arready,lsu_rvalid}
  typedef struct packed {
    logic [11:0] iv;
    logic [11:0] ov;
    logic [31:0] ar;
    logic [31:0] aw;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [11:0] iv, input logic [11:0] ov,
                              input logic [31:0] ar, input logic [31:0] aw, input logic [31:0] wd);
    vec_t v;
    v.iv = iv; v.ov = ov; v.ar = ar; v.aw = aw; v.wd = wd;
    return v;
  endfunction

  function automatic logic [11:0] ov_now();
    return {m_arvalid, m_rready, ifu_arready, ifu_rvalid,
            m_awvalid, m_wvalid, m_bready, lsu_awready, lsu_wready, lsu_bvalid,
            lsu_arready, lsu_rvalid};
  endfunction

  task automatic set_iv(input logic [11:0] iv);
    {ifu_arvalid, ifu_rready, lsu_awvalid, lsu_wvalid, lsu_bready, lsu_arvalid, lsu_rready,
     m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = iv;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock, apply inputs, then compare handshake outputs mid-cycle.
  task automatic step(input string name, input logic [11:0] iv, input logic [11:0] ov);
    @(posedge clk); #1;
    set_iv(iv);
    @(negedge clk);
    check(name, {20'd0, ov_now()}, {20'd0, ov});
  endtask

  task automatic do_reset();
    set_iv('1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ov", {20'd0, ov_now()}, 32'd0);
    check("reset_araddr", m_araddr, 32'd0);
    check("reset_awaddr", m_awaddr, 32'd0);
    check("reset_wdata", m_wdata, 32'd0);
    check("reset_wstrb", {28'd0, m_wstrb}, 32'd0);
    set_iv('0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifu_araddr = 32'h8000_0000;
    lsu_awaddr = 32'ha000_03f8;
    lsu_araddr = 32'h2000_0010;
    lsu_wdata  = 32'h0000_0041;
    lsu_wstrb  = 4'h1;
    m_rdata    = 32'h0000_0013;
    m_rresp    = AXI_RESP_OKAY;
    m_bresp    = AXI_RESP_OKAY;
    set_iv('0);

    // IFU read alone, data three cycles after the AR handshake.
    vecs[0]  = mk(12'b11_00000_00010, 12'b0000_000000_00, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mk(12'b11_00000_00010, 12'b1110_000000_00, 32'h8000_0000, 32'h0, 32'h0);
    vecs[2]  = mk(12'b01_00000_00000, 12'b0100_000000_00, 32'h8000_0000, 32'h0, 32'h0);
    vecs[3]  = mk(12'b01_00000_00000, 12'b0100_000000_00, 32'h8000_0000, 32'h0, 32'h0);
    vecs[4]  = mk(12'b01_00000_00001, 12'b0101_000000_00, 32'h8000_0000, 32'h0, 32'h0);
    vecs[5]  = mk(12'b00_00000_00000, 12'b0000_000000_00, 32'h0, 32'h0, 32'h0);
    // LSU write with W one cycle ahead of AW, then the IDLE bubble before an IFU read.
    vecs[6]  = mk(12'b00_01100_11000, 12'b0000_000000_00, 32'h0, 32'h0, 32'h0);
    vecs[7]  = mk(12'b00_01100_11000, 12'b0000_011110_00, 32'h0, 32'ha000_03f8, 32'h41);
    vecs[8]  = mk(12'b00_10100_11000, 12'b0000_101100_00, 32'h0, 32'ha000_03f8, 32'h41);
    vecs[9]  = mk(12'b00_00100_11000, 12'b0000_001000_00, 32'h0, 32'ha000_03f8, 32'h41);
    vecs[10] = mk(12'b00_00100_11100, 12'b0000_001001_00, 32'h0, 32'ha000_03f8, 32'h41);
    vecs[11] = mk(12'b10_00000_00000, 12'b0000_000000_00, 32'h0, 32'h0, 32'h0);
    vecs[12] = mk(12'b10_00000_00000, 12'b1000_000000_00, 32'h8000_0000, 32'h0, 32'h0);
    vecs[13] = mk(12'b10_00000_00010, 12'b1010_000000_00, 32'h8000_0000, 32'h0, 32'h0);
    vecs[14] = mk(12'b01_00000_00001, 12'b0101_000000_00, 32'h8000_0000, 32'h0, 32'h0);
    vecs[15] = mk(12'b00_00000_00000, 12'b0000_000000_00, 32'h0, 32'h0, 32'h0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d_ov", i), vecs[i].iv, vecs[i].ov);
      check($sformatf("vec%0d_araddr", i), m_araddr, vecs[i].ar);
      check($sformatf("vec%0d_awaddr", i), m_awaddr, vecs[i].aw);
      check($sformatf("vec%0d_wdata", i), m_wdata, vecs[i].wd);
      if (i == 4) check("ifu_rdata", ifu_rdata, 32'h13);
      if (i == 10) check("lsu_bresp", {30'd0, lsu_bresp}, {30'd0, AXI_RESP_OKAY});
    end

    // Both masters read after reset: IFU first, LSU two cycles after the R handshake, IFU again.
    do_reset();
    step("tie_idle",      12'b11_00011_00010, 12'b0000_000000_00);
    step("tie_ifu_ar",    12'b11_00011_00010, 12'b1110_000000_00);
    check("tie_ifu_addr", m_araddr, 32'h8000_0000);
    step("tie_ifu_r",     12'b01_00011_00001, 12'b0101_000000_00);
    step("tie_bubble",    12'b10_00011_00010, 12'b0000_000000_00);
    step("tie_lsu_ar",    12'b10_00011_00010, 12'b1100_000000_10);
    check("tie_lsu_addr", m_araddr, 32'h2000_0010);
    step("tie_lsu_r",     12'b10_00001_00001, 12'b0100_000000_01);
    check("tie_lsu_rdata", lsu_rdata, 32'h13);
    step("tie2_idle",     12'b10_00011_00010, 12'b0000_000000_00);
    step("tie2_ifu_ar",   12'b10_00011_00010, 12'b1010_000000_00);
    check("tie2_ifu_addr", m_araddr, 32'h8000_0000);

    // After an IFU grant, LSU write+read and IFU together: write, IFU read, LSU read.
    do_reset();
    step("pre_idle",      12'b11_00000_00010, 12'b0000_000000_00);
    step("pre_ifu_ar",    12'b11_00000_00010, 12'b1110_000000_00);
    step("pre_ifu_r",     12'b01_00000_00001, 12'b0101_000000_00);
    check("pre_ifu_rresp", {30'd0, ifu_rresp}, {30'd0, AXI_RESP_OKAY});
    step("ord_idle",      12'b11_11111_11010, 12'b0000_000000_00);
    step("ord_wr",        12'b11_11111_11010, 12'b0000_111110_00);
    check("ord_wr_awaddr", m_awaddr, 32'ha000_03f8);
    check("ord_wr_wstrb", {28'd0, m_wstrb}, 32'h1);
    check("ord_wr_araddr", m_araddr, 32'h0);
    step("ord_wr_b",      12'b11_00111_11110, 12'b0000_001001_00);
    step("ord_idle2",     12'b11_00011_00010, 12'b0000_000000_00);
    step("ord_ifu_ar",    12'b11_00011_00010, 12'b1110_000000_00);
    step("ord_ifu_r",     12'b01_00011_00001, 12'b0101_000000_00);
    step("ord_idle3",     12'b00_00011_00010, 12'b0000_000000_00);
    step("ord_lsu_ar",    12'b00_00011_00010, 12'b1100_000000_10);
    check("ord_lsu_addr", m_araddr, 32'h2000_0010);

    // LSU holds rready low for four cycles while data is waiting.
    for (int k = 0; k < 4; k++)
      step($sformatf("bp_hold%0d", k), 12'b10_00000_00001, 12'b0000_000000_01);
    step("bp_release",    12'b10_00001_00001, 12'b0100_000000_01);
    step("bp_idle",       12'b10_00000_00000, 12'b0000_000000_00);
    step("bp_ifu_ar",     12'b10_00000_00000, 12'b1000_000000_00);

    // Reset between the AW handshake and the B response.
    do_reset();
    step("rw_idle",       12'b00_10100_10000, 12'b0000_000000_00);
    step("rw_aw",         12'b00_10100_10000, 12'b0000_101100_00);
    step("rw_w_stall",    12'b00_01100_00000, 12'b0000_011000_00);
    #1 rst = 1'b1;
    #1;
    check("rw_rst_ov", {20'd0, ov_now()}, 32'd0);
    check("rw_rst_awaddr", m_awaddr, 32'd0);
    check("rw_rst_wdata", m_wdata, 32'd0);
    set_iv(12'b10_01100_00000);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rw_post_idle", {20'd0, ov_now()}, 32'd0);
    step("rw_post_ifu",   12'b10_01100_00000, 12'b1000_000000_00);
    check("rw_post_wready", {31'd0, lsu_wready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_arbiter_2to1.md
# axi4_lite_arbiter_2to1

Two-master to one-slave AXI4-Lite arbiter placed directly upstream of the 3-slave AXI4-Lite crossbar. It merges the IFU read-only port and the LSU read/write port into the single master interface that the crossbar decodes by address. Each grant is held for one complete transaction, from address handshake through R/B response handshake. A round-robin pointer prevents either master from starving the other.

## Interface
- ADDR_W, 32, address width of all channels
- DATA_W, 32, data width; strobe width is DATA_W/8
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  IFU read-address channel
- ifu_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  IFU read-data channel
- lsu_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  LSU write-address channel
- lsu_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  LSU write-data channel
- lsu_bresp/bvalid/bready  out/out/in  2/1/1  LSU write-response channel
- lsu_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  LSU read-address channel
- lsu_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  LSU read-data channel
- m_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  crossbar write-address channel
- m_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  crossbar write-data channel
- m_bresp/bvalid/bready  in/in/out  2/1/1  crossbar write-response channel
- m_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  crossbar read-address channel
- m_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  crossbar read-data channel

## Operation
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. One transaction is outstanding at most.
- IDLE arbitration, registered. Requesters are IFU (ifu_arvalid) and LSU (lsu_awvalid|lsu_wvalid|lsu_arvalid).
  - Only one requester: grant it.
  - Both requesters: grant the one not in last_grant.
  - LSU granted with both a write and a read pending: the write wins and the state becomes LSU_WR.
- IFU_RD / LSU_RD forwarding:
  - Granted AR and R channels connect combinationally to m_ar*/m_r*.
  - Non-granted arready and rvalid are held at 0.
  - m_awvalid, m_wvalid and m_bready are held at 0.
  - Exit to IDLE on m_rvalid&&m_rready.
- LSU_WR forwarding:
  - lsu_aw*, lsu_w* and lsu_b* connect to the m_ side. AW and W may handshake in any order or cycle.
  - Exit to IDLE on m_bvalid&&m_bready.
  - All read channels are gated to 0.
- last_grant updates on every grant: 0=IFU, 1=LSU.
- Gating when not granted:
  - m_* address, data and strobe outputs are driven 0.
  - ifu_rdata/lsu_rdata/lsu_bresp mirror the m_ inputs unconditionally; they are qualified only by the valids.
- No response generation of its own. No protocol checking. Upstream masters must hold valid and payload stable until ready (AXI rule).

## Timing
- Reset values:
  - state=IDLE, last_grant=1, so IFU wins the first tie.
  - All valid and ready outputs are 0. m_awaddr, m_wdata, m_wstrb and m_araddr are 0.
- Arbitration latency: a request sampled in IDLE at cycle t appears on the m_ side at t+1.
- Release: a response handshake at cycle u puts the FSM in IDLE at u+1. The next grant is visible at u+2, leaving one bubble cycle per transaction.
- A response handshake and a new request in the same cycle: the request waits for the IDLE cycle.
- Reset mid-transaction: the FSM returns to IDLE and all m_ valids drop immediately (asynchronous). Any in-flight response is dropped.

## Structure
- The shared include holds the response code constants (OKAY/SLVERR/DECERR) and the FSM state localparams: `AXI4_ARB_IDLE/IFU_RD/LSU_RD/LSU_WR`, 2 bits.
- Single module. No sub-module is needed: the round-robin decision is a 2-input expression on last_grant.

## Test plan
- IFU read alone: ifu_araddr=0x80000000, slave returns rdata=0x00000013 after 3 cycles -> m_arvalid at t+1, ifu_rvalid with 0x00000013, lsu_rvalid stays 0.
- LSU write with W one cycle before AW: addr 0xa00003f8, wdata=0x41, wstrb=0x1 -> m_awaddr=0xa00003f8 and m_wdata=0x41 forwarded; lsu_bvalid with bresp=OKAY; FSM reaches IDLE the cycle after the B handshake.
- Simultaneous IFU and LSU reads right after reset -> IFU granted first, LSU granted at the IFU R-handshake cycle + 2; next tie goes to IFU again.
- LSU asserts awvalid and arvalid together with ifu_arvalid, last_grant=IFU -> LSU_WR first, then IFU_RD, then LSU_RD.
- Slave holds m_rready-side back-pressure: lsu_rready=0 for 4 cycles with m_rvalid=1 -> state stays LSU_RD, no new grant, ifu_arready=0 throughout.
- rst pulsed in LSU_WR after AW handshake, before B -> all m_ valids 0 in the same cycle, state IDLE, last_grant=1.
